// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Run/PC/ROM/instruction bundle between fetch_unit and its peers.
//  Revision : 1.0
// ============================================================================
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  run;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  stall;
  logic [DATA_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0] operand;
  logic                  instr_valid;
  logic                  pc_enable;
  logic                  halted;
  logic [DATA_WIDTH-1:0] instr_count;

  // Fetch-unit side
  modport slave (
    input  run, pc, rom_data, stall,
    output rom_addr, opcode, operand, instr_valid, pc_enable, halted, instr_count
  );

  // Environment side (PC, ROM, downstream stages)
  modport master (
    output run, pc, rom_data, stall,
    input  rom_addr, opcode, operand, instr_valid, pc_enable, halted, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Two-word instruction fetch sequencer with stall, halt and count.
//  Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = 16'hFFFF
) (
  input  wire logic         clk,
  input  wire logic         reset,
  fetch_unit_if.slave       bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR_OP  = 3'd1,
    S_ADDR_IMM = 3'd2,
    S_CAPTURE  = 3'd3,
    S_EXEC     = 3'd4,
    S_HALTED   = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_opcode;
  logic [DATA_WIDTH-1:0] r_operand;
  logic [DATA_WIDTH-1:0] r_instr_count;
  logic                  r_halted;

  logic [DATA_WIDTH-1:0] w_rom_addr;
  logic                  w_instr_valid;
  logic                  w_pc_enable;
  logic                  w_latch_op;
  logic                  w_latch_operand;
  logic                  w_set_halt;

  // The PC MSB has no place in a doubled word address and is dropped.
  logic                  w_unused_pc_msb;
  assign w_unused_pc_msb = bus.pc[DATA_WIDTH-1];

  always_comb begin
    w_next          = r_state;
    w_rom_addr      = '0;
    w_instr_valid   = 1'b0;
    w_pc_enable     = 1'b0;
    w_latch_op      = 1'b0;
    w_latch_operand = 1'b0;
    w_set_halt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.run) begin
          w_next = S_ADDR_OP;
        end
      end
      S_ADDR_OP: begin
        w_rom_addr = {bus.pc[DATA_WIDTH-2:0], 1'b0};
        w_next     = S_ADDR_IMM;
      end
      S_ADDR_IMM: begin
        w_rom_addr = {bus.pc[DATA_WIDTH-2:0], 1'b1};
        w_latch_op = 1'b1;
        w_next     = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_rom_addr      = {bus.pc[DATA_WIDTH-2:0], 1'b1};
        w_latch_operand = 1'b1;
        w_next          = S_EXEC;
      end
      S_EXEC: begin
        w_instr_valid = 1'b1;
        // A halt retires nothing and wins over a pending stall.
        if (r_opcode == HALT_OPCODE) begin
          w_set_halt = 1'b1;
          w_next     = S_HALTED;
        end else if (!bus.stall) begin
          w_pc_enable = 1'b1;
          w_next      = bus.run ? S_ADDR_OP : S_IDLE;
        end
      end
      S_HALTED: begin
        w_next = S_HALTED;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_opcode      <= '0;
      r_operand     <= '0;
      r_instr_count <= '0;
      r_halted      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch_op) begin
        r_opcode <= bus.rom_data;
      end
      if (w_latch_operand) begin
        r_operand <= bus.rom_data;
      end
      if (w_pc_enable) begin
        r_instr_count <= r_instr_count + 1'b1;
      end
      if (w_set_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Reset masks the strobes so an interrupted EXEC never advances the PC.
  assign bus.rom_addr    = reset ? '0 : w_rom_addr;
  assign bus.instr_valid = w_instr_valid & ~reset;
  assign bus.pc_enable   = w_pc_enable & ~reset;
  assign bus.opcode      = r_opcode;
  assign bus.operand     = r_operand;
  assign bus.halted      = r_halted;
  assign bus.instr_count = r_instr_count;

endmodule
`default_nettype wire
